maxpool2x2_stream: RTL



---
 rtl/cnn_pkg.sv | 23 ++
 rtl/maxpool2x2_stream_if.sv | 34 +++
 rtl/maxpool2x2_stream_fp32_max.sv | 44 ++++
 rtl/maxpool2x2_stream.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
//   Shared constants and types for the CNN streaming layers.
//   - DATA_WIDHT / CHANNEL : default sample width (fp32) and channels per pixel
//   - FP32_SIGN_BIT / FP32_MAG_MSB : bit positions used by the fp32 comparator
//   - pix_action_e : what the pooling stage does with the pixel seen this cycle
// ---------------------------------------------------------------------------
package cnn_pkg;

    localparam int DATA_WIDHT    = 32;
    localparam int CHANNEL       = 8;
    localparam int FP32_SIGN_BIT = 31;
    localparam int FP32_MAG_MSB  = 30;

    typedef enum logic [2:0] {
        ACT_IDLE,   // no pixel this cycle
        ACT_SKIP,   // pixel in a floored-away last row/column
        ACT_PAIR,   // even column: remember left pixel of the pair
        ACT_STORE,  // odd column, even row: park horizontal max in row buffer
        ACT_EMIT    // odd column, odd row: window complete, emit pooled pixel
    } pix_action_e;

endpackage

// File: rtl/maxpool2x2_stream_if.sv
// ---------------------------------------------------------------------------
// maxpool2x2_stream_if
//   Pixel stream bundle around the pooling stage (Layer2 -> pool -> next conv).
//   Valid_In / Data_In  : upstream pixel and its qualifier
//   Data_Out / Valid_Out: pooled pixel and its one-cycle qualifier
//   Channel k of a pixel lives at [k*DATA_WIDHT +: DATA_WIDHT].
//   master: the side that drives pixels in and observes pooled output.
//   slave : the pooling stage itself.
// ---------------------------------------------------------------------------
interface maxpool2x2_stream_if #(
    parameter int DATA_WIDHT = cnn_pkg::DATA_WIDHT,
    parameter int CHANNEL    = cnn_pkg::CHANNEL
);

    logic                          Valid_In;
    logic [DATA_WIDHT*CHANNEL-1:0] Data_In;
    logic [DATA_WIDHT*CHANNEL-1:0] Data_Out;
    logic                          Valid_Out;

    modport master (
        output Valid_In,
        output Data_In,
        input  Data_Out,
        input  Valid_Out
    );

    modport slave (
        input  Valid_In,
        input  Data_In,
        output Data_Out,
        output Valid_Out
    );

endinterface

// File: rtl/maxpool2x2_stream_fp32_max.sv
// ---------------------------------------------------------------------------
// fp32_max
//   Combinational max of two fp32 values decided purely on bit patterns.
//   a_i, b_i : operands
//   max_o    : the larger operand; a_i on identical patterns
//   Positive beats negative (so +0 beats -0); among positives the larger
//   magnitude field wins, among negatives the smaller one. NaN/denormal
//   patterns are not special-cased.
// ---------------------------------------------------------------------------
module fp32_max
    import cnn_pkg::*;
(
    input  logic [DATA_WIDHT-1:0] a_i,
    input  logic [DATA_WIDHT-1:0] b_i,
    output logic [DATA_WIDHT-1:0] max_o
);

    logic                  sign_a;
    logic                  sign_b;
    logic [FP32_MAG_MSB:0] mag_a;
    logic [FP32_MAG_MSB:0] mag_b;
    logic                  pick_b;

    assign sign_a = a_i[FP32_SIGN_BIT];
    assign sign_b = b_i[FP32_SIGN_BIT];
    assign mag_a  = a_i[FP32_MAG_MSB:0];
    assign mag_b  = b_i[FP32_MAG_MSB:0];

    // NOTE: every variable written in an always_comb gets a value on every
    // path (default first) so no latch is inferred.
    always_comb begin
        pick_b = 1'b0;
        if (sign_a != sign_b) begin
            pick_b = sign_a;            // b is the non-negative one
        end else if (!sign_a) begin
            pick_b = (mag_b > mag_a);
        end else begin
            pick_b = (mag_b < mag_a);
        end
    end

    assign max_o = pick_b ? b_i : a_i;

endmodule

// File: rtl/maxpool2x2_stream.sv
// ---------------------------------------------------------------------------
// maxpool2x2_stream
//   Streaming 2x2 / stride-2 max pooling over a raster-order pixel stream,
//   all channels in parallel.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (abandons any frame in flight)
//   bus : maxpool2x2_stream_if.slave (Valid_In/Data_In in, Data_Out/Valid_Out out)
//   Even rows leave per-pair horizontal maxima in a half-width row buffer;
//   odd rows combine with it and emit one pooled pixel per window, registered
//   on the edge that accepts the window's bottom-right pixel. Odd trailing
//   rows/columns are dropped.
// ---------------------------------------------------------------------------
module maxpool2x2_stream #(
    parameter int DATA_WIDHT = cnn_pkg::DATA_WIDHT,
    parameter int CHANNEL    = cnn_pkg::CHANNEL,
    parameter int IMG_WIDTH  = 44,
    parameter int IMG_HEIGHT = 44
) (
    input  logic               clk,
    input  logic               rst,
    maxpool2x2_stream_if.slave bus
);

    localparam int PW     = DATA_WIDHT * CHANNEL;
    localparam int OUT_W  = IMG_WIDTH / 2;
    localparam int COL_W  = $clog2(IMG_WIDTH);
    localparam int ROW_W  = $clog2(IMG_HEIGHT);
    localparam int BUF_AW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0] col_q,       col_d;
    logic [ROW_W-1:0] row_q,       row_d;
    logic [PW-1:0]    pair_q,      pair_d;
    logic [PW-1:0]    data_out_q,  data_out_d;
    logic             valid_out_q, valid_out_d;

    logic [PW-1:0]     rowbuf_q [OUT_W];
    logic [BUF_AW-1:0] buf_idx;
    logic [PW-1:0]     rowbuf_rd;
    logic [PW-1:0]     hmax;
    logic [PW-1:0]     vmax;

    logic                 col_drop;
    logic                 row_drop;
    cnn_pkg::pix_action_e act;

    // Trailing column/row only exist to be dropped when the dimension is odd.
    assign col_drop = (IMG_WIDTH  % 2 == 1) && (col_q == COL_MAX);
    assign row_drop = (IMG_HEIGHT % 2 == 1) && (row_q == ROW_MAX);

    assign buf_idx   = BUF_AW'(col_q >> 1);
    assign rowbuf_rd = rowbuf_q[buf_idx];

    // Per channel: horizontal max of the pair, then vertical max against the
    // row above.
    for (genvar k = 0; k < CHANNEL; k++) begin : g_ch
        fp32_max u_hmax (
            .a_i   (pair_q[k*DATA_WIDHT +: DATA_WIDHT]),
            .b_i   (bus.Data_In[k*DATA_WIDHT +: DATA_WIDHT]),
            .max_o (hmax[k*DATA_WIDHT +: DATA_WIDHT])
        );
        fp32_max u_vmax (
            .a_i   (rowbuf_rd[k*DATA_WIDHT +: DATA_WIDHT]),
            .b_i   (hmax[k*DATA_WIDHT +: DATA_WIDHT]),
            .max_o (vmax[k*DATA_WIDHT +: DATA_WIDHT])
        );
    end

    // Classify the incoming pixel by its position parity.
    always_comb begin
        act = cnn_pkg::ACT_IDLE;
        if (bus.Valid_In) begin
            if (col_drop || row_drop) begin
                act = cnn_pkg::ACT_SKIP;
            end else if (!col_q[0]) begin
                act = cnn_pkg::ACT_PAIR;
            end else if (!row_q[0]) begin
                act = cnn_pkg::ACT_STORE;
            end else begin
                act = cnn_pkg::ACT_EMIT;
            end
        end
    end

    // Next-state: raster counters advance only on accepted pixels.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        pair_d      = pair_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;

        if (bus.Valid_In) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        case (act)
            cnn_pkg::ACT_PAIR: pair_d = bus.Data_In;
            cnn_pkg::ACT_EMIT: begin
                data_out_d  = vmax;
                valid_out_d = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            pair_q      <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            pair_q      <= pair_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    // NOTE: the row buffer is deliberately not reset: every entry is written
    // on an even row before the odd row that reads it, so clearing it would
    // only cost reset fan-out and block RAM inference.
    always_ff @(posedge clk) begin
        if (!rst && act == cnn_pkg::ACT_STORE) begin
            rowbuf_q[buf_idx] <= hmax;
        end
    end

    assign bus.Data_Out  = data_out_q;
    assign bus.Valid_Out = valid_out_q;

endmodule
